// File: rtl/led_shift_ctrl.sv
// Serial shift controller for STP16-style LED drivers.
// Handles word transfer, SDO readback capture and PWM blanking.
module led_shift_ctrl #(
    parameter int C_N     = 16,
    parameter int C_DIV   = 2,
    parameter int C_PWM_W = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [C_N-1:0]     Data_In,
    input  logic               Data_Valid,
    output logic               Data_Ready,
    input  logic [C_PWM_W-1:0] Bright,
    output logic               LED_Clk,
    output logic               LED_SDI,
    output logic               LED_LE,
    output logic               LED_OE,
    input  logic               LED_SDO,
    output logic [C_N-1:0]     Readback,
    output logic               Busy,
    output logic               Done
);

    localparam int PW = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int BW = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(C_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(C_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t state, state_nx;

    logic [PW-1:0]      phase;
    logic [BW-1:0]      bitc;
    logic [C_N-1:0]     sreg;
    logic [C_N-1:0]     cap;
    logic [C_N-1:0]     rb;
    logic               done_q;
    logic [C_PWM_W-1:0] pwm_cnt;
    logic [C_PWM_W-1:0] shadow;
    logic               ph_last;
    logic               bit_last;

    assign ph_last  = (phase == PH_LAST);
    assign bit_last = (bitc == BIT_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        LED_Clk    = 1'b0;
        LED_LE     = 1'b0;
        Busy       = 1'b1;
        Data_Ready = 1'b0;
        unique case (state)
            IDLE: begin
                Busy       = 1'b0;
                Data_Ready = ~Rst;
                if (Data_Valid) state_nx = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (ph_last) state_nx = SHIFT_HI;
            end
            SHIFT_HI: begin
                LED_Clk = 1'b1;
                if (ph_last) state_nx = bit_last ? LATCH : SHIFT_LO;
            end
            LATCH: begin
                LED_LE = 1'b1;
                if (ph_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            phase  <= '0;
            bitc   <= '0;
            sreg   <= '0;
            cap    <= '0;
            rb     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == LATCH) && ph_last;
            if (state == IDLE || ph_last) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
            if (state == IDLE && Data_Valid) begin
                sreg <= Data_In;
                bitc <= '0;
            end
            // Old driver MSB is stable right before the clock rises
            if (state == SHIFT_LO && ph_last) begin
                cap <= {cap[C_N-2:0], LED_SDO};
            end
            if (state == SHIFT_HI && ph_last) begin
                sreg <= {sreg[C_N-2:0], 1'b0};
                bitc <= bitc + 1'b1;
            end
            if (state == LATCH && ph_last) begin
                rb <= cap;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pwm_cnt <= '0;
            shadow  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '0) shadow <= Bright;
        end
    end

    assign LED_OE   = ~(pwm_cnt < shadow);
    assign LED_SDI  = sreg[C_N-1];
    assign Readback = rb;
    assign Done     = done_q;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Bench for led_shift_ctrl with an attached STP16 driver model.
// Random words and brightness checked against timing/PWM rules.
module tb_led_shift_ctrl;

    localparam int N  = 16;
    localparam int D  = 2;
    localparam int DK = 1 + D * (2 * N + 1);
    localparam int LE_LO = 1 + 2 * D * N;
    localparam int LE_HI = D * (2 * N + 1);

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [N-1:0] Data_In = '0;
    logic         Data_Valid = 1'b0;
    logic         Data_Ready;
    logic [3:0]   Bright = '0;
    logic         LED_Clk;
    logic         LED_SDI;
    logic         LED_LE;
    logic         LED_OE;
    logic         LED_SDO;
    logic [N-1:0] Readback;
    logic         Busy;
    logic         Done;

    logic [N-1:0] drv = '0;
    logic [N-1:0] po = '0;

    int cmp  = 0;
    int errs = 0;
    int n    = 0;
    int eff  = 0;
    logic [N-1:0] drv_exp = '0;
    logic [N-1:0] po_exp  = '0;

    led_shift_ctrl #(.C_N(N), .C_DIV(D), .C_PWM_W(4)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Data_In(Data_In),
        .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready),
        .Bright(Bright),
        .LED_Clk(LED_Clk),
        .LED_SDI(LED_SDI),
        .LED_LE(LED_LE),
        .LED_OE(LED_OE),
        .LED_SDO(LED_SDO),
        .Readback(Readback),
        .Busy(Busy),
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge LED_Clk) drv <= {drv[N-2:0], LED_SDI};
    assign LED_SDO = drv[N-1];
    always @(posedge Clk) if (LED_LE) po <= drv;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // PWM rule: period phase since reset, brightness taken at period start
    task automatic step();
        logic       r;
        logic [3:0] b;
        r = Rst;
        b = Bright;
        @(posedge Clk);
        #1;
        if (r) begin
            n   = 0;
            eff = 0;
        end else begin
            n++;
            if (n % 16 == 1) eff = int'(b);
        end
        chk("oe", {31'b0, LED_OE}, ((n % 16) < eff) ? 32'd0 : 32'd1);
    endtask

    task automatic idle(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            step();
            chk("idle_busy", {31'b0, Busy}, 32'd0);
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_clk", {31'b0, LED_Clk}, 32'd0);
        chk("rst_sdi", {31'b0, LED_SDI}, 32'd0);
        chk("rst_le", {31'b0, LED_LE}, 32'd0);
        chk("rst_oe", {31'b0, LED_OE}, 32'd1);
        chk("rst_rb", {16'b0, Readback}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_rdy", {31'b0, Data_Ready}, 32'd0);
    endtask

    task automatic xfer(input logic [N-1:0] word, input bit hold,
                        input int abort_k);
        logic [2*N-1:0] tmp;
        int             r;
        Data_In    = word;
        Data_Valid = 1'b1;
        chk("hs_rdy", {31'b0, Data_Ready}, 32'd1);
        for (int k = 1; k <= DK; k++) begin
            step();
            if (k == 1) begin
                if (hold) Data_In = 16'hFFFF;
                else Data_Valid = 1'b0;
            end
            if (k == 10) Bright = 4'($urandom_range(0, 15));
            chk("clk", {31'b0, LED_Clk},
                (k <= 2 * D * N && ((k - 1) / D) % 2 == 1) ? 32'd1 : 32'd0);
            chk("le", {31'b0, LED_LE},
                (k >= LE_LO && k <= LE_HI) ? 32'd1 : 32'd0);
            chk("le_clk", {31'b0, LED_LE & LED_Clk}, 32'd0);
            chk("done", {31'b0, Done}, (k == DK) ? 32'd1 : 32'd0);
            chk("busy", {31'b0, Busy}, (k < DK) ? 32'd1 : 32'd0);
            chk("rdy", {31'b0, Data_Ready}, (k == DK) ? 32'd1 : 32'd0);
            if (k <= 2 * D * N)
                chk("sdi", {31'b0, LED_SDI},
                    {31'b0, word[N - 1 - (k - 1) / (2 * D)]});
            if (abort_k != 0 && k == abort_k) begin
                Rst        = 1'b1;
                Data_Valid = 1'b0;
                step();
                check_reset_outs();
                step();
                check_reset_outs();
                Rst = 1'b0;
                r = 0;
                for (int kk = 1; kk <= abort_k; kk++)
                    if ((kk - 1) % (2 * D) == D) r++;
                tmp     = {drv_exp, word} << r;
                drv_exp = tmp[2*N-1 -: N];
                return;
            end
        end
        chk("rb", {16'b0, Readback}, {16'b0, drv_exp});
        chk("po", {16'b0, po}, {16'b0, word});
        drv_exp    = word;
        po_exp     = word;
        Data_Valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] w;
        Rst = 1'b1;
        step();
        check_reset_outs();
        step();
        check_reset_outs();
        Rst    = 1'b0;
        Bright = 4'd5;
        idle(40);
        chk("rdy_idle", {31'b0, Data_Ready}, 32'd1);
        xfer(16'hA5C3, 1'b0, 0);
        xfer(16'h1234, 1'b0, 0);
        idle(3);
        w = 16'($urandom);
        xfer(w, 1'b1, 0);
        idle(2);
        chk("hold_ignored", {16'b0, po}, {16'b0, w});
        Bright = 4'd0;
        idle(36);
        Bright = 4'd15;
        idle(36);
        for (int i = 0; i < 3; i++) begin
            Bright = 4'($urandom_range(0, 15));
            xfer(16'($urandom), 1'b0, 0);
            idle(int'($urandom_range(0, 5)));
        end
        xfer(16'($urandom), 1'b0, 30);
        for (int i = 0; i < 80; i++) begin
            step();
            chk("abort_le", {31'b0, LED_LE}, 32'd0);
        end
        chk("abort_po", {16'b0, po}, {16'b0, po_exp});
        Bright = 4'($urandom_range(1, 15));
        xfer(16'($urandom), 1'b0, 0);
        idle(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule

// File: doc/led_shift_ctrl.md
LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

Interface
REQ-001 Parameter C_N, default 16: bits per STP16D05 word, width of Data_In and Readback.
REQ-002 Parameter C_DIV, default 2: Clk cycles per LED_Clk half-period; legal range ≥1.
REQ-003 Parameter C_PWM_W, default 4: width of Bright and of the PWM counter.
REQ-004 Clk  in  1  system clock; all logic on rising edge.
REQ-005 Rst  in  1  reset, synchronous and active-high.
REQ-006 Data_In  in  C_N  word to display; bit C_N-1 drives LED_PO[C_N-1].
REQ-007 Data_Valid  in  1  Data_In valid.
REQ-008 Data_Ready  out  1  controller idle, word accepted on Data_Valid & Data_Ready.
REQ-009 Bright  in  C_PWM_W  brightness; 0 = dark.
REQ-010 LED_Clk  out  1  shift clock to driver.
REQ-011 LED_SDI  out  1  serial data to driver.
REQ-012 LED_LE  out  1  latch enable, active-high.
REQ-013 LED_OE  out  1  output blank, active-high (1 = LED outputs forced 0).
REQ-014 LED_SDO  in  1  serial data from driver (previous contents).
REQ-015 Readback  out  C_N  previous driver word captured from LED_SDO during the last transfer.
REQ-016 Busy  out  1  transfer in progress.
REQ-017 Done  out  1  one-cycle pulse at transfer completion.

Function
REQ-018 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH; a C_DIV-cycle phase counter and a bit counter (0..C_N-1) sequence them.
REQ-019 IDLE: Data_Ready=1, Busy=0, LED_Clk=0, LED_LE=0; on handshake, Data_In loads the shift register and the next state is SHIFT_LO with bit counter 0.
REQ-020 SHIFT_LO: LED_Clk=0, LED_SDI=current MSB of shift register, held C_DIV cycles, then SHIFT_HI.
REQ-021 SHIFT_HI: LED_Clk=1, LED_SDI unchanged, held C_DIV cycles; LED_SDO sampled into the Readback capture register (MSB first) in the last SHIFT_LO cycle before LED_Clk rises.
REQ-022 Leaving SHIFT_HI: shift register shifts left one; if bit counter = C_N-1 go to LATCH, else increment and go to SHIFT_LO.
REQ-023 LATCH: LED_Clk=0, LED_LE=1 for C_DIV cycles; then IDLE, with Done=1 and Readback updated in that first IDLE cycle.
REQ-024 LED_LE shall never be high while LED_Clk is high; LED_SDI shall change only while LED_Clk is low.
REQ-025 Latency: handshake in cycle t -> first LED_Clk rise at t+1+C_DIV, LED_LE high t+1+2·C_DIV·C_N .. t+C_DIV·(2·C_N+1), Done at t+1+C_DIV·(2·C_N+1).
REQ-026 Busy = not IDLE; Data_Ready = IDLE; Data_Valid outside IDLE is ignored, not queued.
REQ-027 Back-to-back: handshake permitted in the Done cycle; next transfer starts the following cycle.
REQ-028 PWM: free-running C_PWM_W-bit counter, wraps 2^C_PWM_W-1 -> 0; Bright sampled into a shadow register when the counter is 0.
REQ-029 LED_OE = 0 when counter < shadow Bright, else 1; Bright=0 -> OE constantly 1; Bright=max -> OE=1 one cycle per period.
REQ-030 PWM runs independently of the FSM, including during shifting and latching.

Reset
REQ-031 Rst=1 at a rising edge: state IDLE, counters 0, shadow Bright 0, LED_Clk=0, LED_SDI=0, LED_LE=0, LED_OE=1, Readback=0, Done=0, Busy=0; Data_Ready=0 while Rst=1.
REQ-032 Rst mid-transfer aborts the transfer; no LED_LE pulse, no Done, Readback unchanged from 0.

Verification (C_N=16, C_DIV=2, C_PWM_W=4, LED_driver model attached, SDO looped)
REQ-033 Rst then Data_In=0xA5C3 handshake at t -> 16 LED_Clk pulses of 4 cycles, LE high t+65..t+66, Done at t+67, model LED_PO=0xA5C3 when OE=0.
REQ-034 Second word 0x1234 handshaked in Done cycle -> LED_PO=0x1234, Readback=0xA5C3.
REQ-035 Data_Valid held high with 0xFFFF during a transfer -> ignored, Data_Ready=0 until Done.
REQ-036 Rst asserted at cycle 30 of a transfer -> next cycle all outputs at reset values, LE never pulses, LED_PO unchanged.
REQ-037 Bright=0 -> LED_OE=1 always; Bright=5 -> LED_OE=0 for 5 of every 16 cycles; Bright changed mid-period takes effect at next counter wrap.
